m_seq_checker: RTL and testbench
================================

# m_seq_checker

Receive-side companion to `m_seq`. It takes a serial bit stream qualified by a valid strobe and self-synchronises a local LFSR to the incoming m-sequence. After lock it flywheels the LFSR and counts bit errors, which gives BER measurement on the BPSK link. It sits after the demodulator/bit slicer, or directly on `m_seq` `data_out`/`data_vld` in loopback benches.

## Interface
- `WIDTH`, 7: LFSR degree.
- `TAPS`, 7'b1100000: feedback mask over state bits. The default gives x^7+x^6+1.
- `LOCK_CNT`, 16: consecutive correct predictions required to declare lock.
- `WIN`, 64: loss-of-lock observation window, in valid bits.
- `LOSS_THRESH`, 8: errors within one window that force loss of lock.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in 1: received bit. Sampled only when `data_vld`=1.
- `data_vld` in 1: one-cycle strobe qualifying `data_in`. It may be high any number of consecutive cycles.
- `clr` in 1: synchronous clear of `err_cnt`/`bit_cnt`.
- `locked` out 1: sequence lock indicator.
- `bit_err` out 1: one-cycle pulse per mismatched bit while locked.
- `err_cnt` out 16: saturating error count.
- `bit_cnt` out 32: saturating count of bits checked while locked.

## Operation
- State register `s[WIDTH-1:0]`. `s[0]` is the newest bit and `s[k]` is the bit from k+1 valid bits ago.
- Prediction is `p = ^(s & TAPS)`. A shift inserts the new bit at `s[0]`.
- The FSM acts only on cycles with `data_vld`=1.
- **LOAD**
  - Shift `data_in` into `s` and increment load counter `ld`.
  - When `ld` reaches WIDTH: go to VERIFY if the new `s` is non-zero. Otherwise stay in LOAD with `ld` held at WIDTH, so the next bit is re-checked.
- **VERIFY**
  - Compare `data_in` with `p` and shift `p` into `s`.
  - On a match, increment `vcnt`. When `vcnt` reaches LOCK_CNT, go to LOCKED.
  - On a mismatch, go to LOAD with `ld`=0 and `vcnt`=0.
  - Nothing is counted in `err_cnt`/`bit_cnt` in this state.
- **LOCKED**
  - Compare `data_in` with `p` and shift `p` into `s`. This is flywheel mode: errors do not corrupt the state.
  - Increment `bit_cnt`.
  - On a mismatch: pulse `bit_err` and increment `err_cnt` and `wec`.
  - `wcnt` counts valid bits 0..WIN-1.
  - If `wec` reaches LOSS_THRESH, go to LOAD (`ld`=`vcnt`=`wec`=`wcnt`=0). Loss takes priority over a window wrap on the same bit.
  - Otherwise, on the WIN-th bit, `wcnt` and `wec` return to 0.
- Both counters saturate: `err_cnt` at 16'hFFFF and `bit_cnt` at 32'hFFFFFFFF.
- `clr`=1 zeroes both counters. When `clr` and an increment occur in the same cycle, the result is 0.
- `clr` does not affect the FSM or lock state.

## Timing
- Reset values:
  - State LOAD.
  - `s`, `ld`, `vcnt`, `wcnt`, `wec` are 0.
  - `locked`=0, `bit_err`=0, `err_cnt`=0, `bit_cnt`=0.
- All outputs are registered. A response appears on the cycle after the sampling edge of the causing `data_vld` bit.
- `locked` rises on the cycle after the edge that accepts the LOCK_CNT-th matching bit. From a clean stream that is WIDTH+LOCK_CNT valid bits after reset (23 by default).
- `locked` falls on the cycle after the edge that accepts the error making `wec`=LOSS_THRESH. That bit still pulses `bit_err` and is counted.
- `bit_err` is high for exactly one cycle per erroneous valid bit. Back-to-back strobes give back-to-back pulses.
- Gaps in `data_vld` (e.g. one strobe every 50 cycles) have no effect. The timeouts count bits, not cycles.
- Reset mid-operation immediately returns all state to reset values, asynchronously.

## Test plan
- **Clean lock.** `m_seq` default (x^7+x^6+1), `en` every 50 cycles. Required response:
  - `locked` rises exactly after the 23rd `data_vld`.
  - After 1000 bits: `err_cnt`=0 and `bit_cnt`=977.
- **Single error.** Invert bit 200 of a locked stream. Required response:
  - One `bit_err` pulse and `err_cnt`=1.
  - `locked` stays 1 and the LFSR stays aligned: no further errors over the next 500 bits.
- **Loss and relock.** Invert 8 bits within one 64-bit window. Required response:
  - `locked` drops on the cycle after the 8th error; `err_cnt`=8.
  - `locked` reasserts after 23 further clean bits.
  - 7 errors in a window never cause loss.
- **Degenerate input.**
  - All-zero input for 500 bits: `locked` never asserts and the FSM stays in LOAD.
  - An error during VERIFY (bit 15 of the 16) restarts acquisition: lock arrives 23 bits after the error.
- **Counters.** Required response:
  - `clr` pulsed on the same cycle as a `bit_err` leaves `err_cnt`=0.
  - `err_cnt` forced near the limit (alternating-inverted stream with LOSS_THRESH=WIN+1) holds at 16'hFFFF.
- **Reset mid-lock.** Assert `rst` asynchronously between edges while `locked`=1. Required response:
  - All outputs go to 0 before the next edge.
  - Relock takes 23 bits after release.

Source files
------------

// File: rtl/m_seq_checker.sv
// Self-synchronising m-sequence checker: acquires lock on a serial PRBS stream,
// then flywheels its LFSR and counts bit errors for BER measurement.
module m_seq_checker #(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] TAPS        = 7'b1100000,
  parameter int               LOCK_CNT    = 16,
  parameter int               WIN         = 64,
  parameter int               LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  input  logic        data_vld,
  input  logic        clr,
  output logic        locked,
  output logic        bit_err,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt,
  output logic [1:0]  dbg_state
);

  localparam int LDW = $clog2(WIDTH + 1);
  localparam int VCW = $clog2(LOCK_CNT + 1);
  localparam int WCW = $clog2(WIN + 1);
  localparam int WEW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_s;
  logic [LDW-1:0]   r_ld;
  logic [VCW-1:0]   r_vcnt;
  logic [WCW-1:0]   r_wcnt;
  logic [WEW-1:0]   r_wec;
  logic             r_locked;
  logic             r_bit_err;
  logic [15:0]      r_err_cnt;
  logic [31:0]      r_bit_cnt;

  logic             w_p;
  logic             w_mis;
  logic [WIDTH-1:0] w_s_load;
  logic [WIDTH-1:0] w_s_fly;
  logic [LDW-1:0]   w_ld_nxt;
  logic [VCW-1:0]   w_vcnt_nxt;
  logic [WEW-1:0]   w_wec_nxt;
  logic             w_err_inc;
  logic             w_bit_inc;

  assign w_p        = ^(r_s & TAPS);
  assign w_mis      = data_in ^ w_p;
  assign w_s_load   = {r_s[WIDTH-2:0], data_in};
  // In verify/locked the prediction, not the received bit, feeds the register
  assign w_s_fly    = {r_s[WIDTH-2:0], w_p};
  assign w_ld_nxt   = (r_ld == LDW'(WIDTH)) ? r_ld : r_ld + LDW'(1);
  assign w_vcnt_nxt = r_vcnt + VCW'(1);
  assign w_wec_nxt  = r_wec + WEW'(w_mis);
  assign w_bit_inc  = data_vld && (r_state == ST_LOCKED);
  assign w_err_inc  = w_bit_inc && w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_s       <= '0;
      r_ld      <= '0;
      r_vcnt    <= '0;
      r_wcnt    <= '0;
      r_wec     <= '0;
      r_locked  <= 1'b0;
      r_bit_err <= 1'b0;
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_bit_err <= 1'b0;

      if (clr) begin
        r_err_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_err_inc && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 16'd1;
        if (w_bit_inc && !(&r_bit_cnt)) r_bit_cnt <= r_bit_cnt + 32'd1;
      end

      if (data_vld) begin
        case (r_state)
          ST_LOAD: begin
            r_s  <= w_s_load;
            r_ld <= w_ld_nxt;
            if (w_ld_nxt == LDW'(WIDTH) && |w_s_load) begin
              r_state <= ST_VERIFY;
              r_vcnt  <= '0;
            end
          end
          ST_VERIFY: begin
            r_s <= w_s_fly;
            if (w_mis) begin
              r_state <= ST_LOAD;
              r_ld    <= '0;
              r_vcnt  <= '0;
            end else if (w_vcnt_nxt == VCW'(LOCK_CNT)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_vcnt   <= w_vcnt_nxt;
              r_wcnt   <= '0;
              r_wec    <= '0;
            end else begin
              r_vcnt <= w_vcnt_nxt;
            end
          end
          ST_LOCKED: begin
            r_s       <= w_s_fly;
            r_bit_err <= w_mis;
            // Loss of lock wins over a window wrap on the same bit
            if (w_wec_nxt == WEW'(LOSS_THRESH)) begin
              r_state  <= ST_LOAD;
              r_locked <= 1'b0;
              r_ld     <= '0;
              r_vcnt   <= '0;
              r_wec    <= '0;
              r_wcnt   <= '0;
            end else if (r_wcnt == WCW'(WIN - 1)) begin
              r_wcnt <= '0;
              r_wec  <= '0;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
              r_wec  <= w_wec_nxt;
            end
          end
          default: begin
            r_state  <= ST_LOAD;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign bit_err   = r_bit_err;
  assign err_cnt   = r_err_cnt;
  assign bit_cnt   = r_bit_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_m_seq_checker.sv
// Bench for m_seq_checker: PRBS source model, spec-level checker model,
// directed scenarios plus randomized error/gap/clear stimulus.
module tb_m_seq_checker;

  localparam int         WIDTH    = 7;
  localparam logic [6:0] TAPS     = 7'b1100000;
  localparam int         LOCK_CNT = 16;
  localparam int         WIN      = 64;
  localparam int         LOSS     = 8;

  logic        clk, rst;
  logic        data_in, data_vld, clr;
  logic        locked, bit_err;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;
  logic [1:0]  dbg_state;

  logic        sat_in, sat_vld, sat_clr;
  logic        sat_locked, sat_bit_err;
  logic [15:0] sat_err_cnt;
  logic [31:0] sat_bit_cnt;
  logic [1:0]  sat_dbg;

  int total = 0;
  int bad   = 0;

  m_seq_checker #(.WIDTH(WIDTH), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THRESH(LOSS)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld), .clr(clr),
    .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt), .dbg_state(dbg_state)
  );

  m_seq_checker #(.WIDTH(WIDTH), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THRESH(WIN + 1)) u_sat (
    .clk(clk), .rst(rst), .data_in(sat_in), .data_vld(sat_vld), .clr(sat_clr),
    .locked(sat_locked), .bit_err(sat_bit_err), .err_cnt(sat_err_cnt), .bit_cnt(sat_bit_cnt),
    .dbg_state(sat_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- PRBS source: x[n] = XOR of TAPS[k] * x[n-1-k] ----------------
  bit tx_q[$];

  task automatic next_tx(output bit b);
    b = 1'b0;
    for (int k = 0; k < WIDTH; k++)
      if (TAPS[k]) b ^= tx_q[WIDTH - 1 - k];
    tx_q.push_back(b);
    void'(tx_q.pop_front());
  endtask

  // ---------------- reference model ----------------
  int      m_mode;  // 0 acquiring, 1 verifying, 2 locked
  bit      m_hist[$];
  int      m_ld, m_vcnt, m_wcnt, m_wec;
  int      m_err;
  longint  m_bits;
  bit      m_bit_err, m_locked;

  task automatic model_reset();
    m_mode = 0;
    m_hist.delete();
    for (int i = 0; i < WIDTH; i++) m_hist.push_back(1'b0);
    m_ld = 0; m_vcnt = 0; m_wcnt = 0; m_wec = 0;
    m_err = 0; m_bits = 0; m_bit_err = 0; m_locked = 0;
  endtask

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int k = 0; k < WIDTH; k++)
      if (TAPS[k]) p ^= m_hist[WIDTH - 1 - k];
    return p;
  endfunction

  task automatic model_step(input bit b, input bit c);
    bit p, inc_b, inc_e, any;
    p = model_pred();
    inc_b = 0; inc_e = 0; any = 0; m_bit_err = 0;
    if (m_mode == 0) begin
      m_hist.push_back(b); void'(m_hist.pop_front());
      if (m_ld < WIDTH) m_ld++;
      foreach (m_hist[i]) any |= m_hist[i];
      if (m_ld == WIDTH && any) begin m_mode = 1; m_vcnt = 0; end
    end else if (m_mode == 1) begin
      m_hist.push_back(p); void'(m_hist.pop_front());
      if (b != p) begin m_mode = 0; m_ld = 0; m_vcnt = 0; end
      else begin
        m_vcnt++;
        if (m_vcnt == LOCK_CNT) begin m_mode = 2; m_wcnt = 0; m_wec = 0; end
      end
    end else begin
      m_hist.push_back(p); void'(m_hist.pop_front());
      inc_b = 1;
      if (b != p) begin m_bit_err = 1; inc_e = 1; m_wec++; end
      if (m_wec == LOSS) begin m_mode = 0; m_ld = 0; m_vcnt = 0; m_wec = 0; m_wcnt = 0; end
      else if (m_wcnt == WIN - 1) begin m_wcnt = 0; m_wec = 0; end
      else m_wcnt++;
    end
    if (c) begin m_err = 0; m_bits = 0; end
    else begin
      if (inc_e && m_err < 65535) m_err++;
      if (inc_b && m_bits < 64'hFFFF_FFFF) m_bits++;
    end
    m_locked = (m_mode == 2);
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_vld = 1'b0; clr = 1'b0; sat_vld = 1'b0;
    end
  endtask

  // Outputs are valid on return (1 time unit after the sampling edge).
  task automatic send_bit(input bit b, input bit c, input int gap);
    idle(gap);
    @(negedge clk);
    data_in = b; data_vld = 1'b1; clr = c;
    @(posedge clk);
    model_step(b, c);
    #1;
  endtask

  task automatic send_tx(input bit inv, input bit c, input int gap);
    bit b;
    next_tx(b);
    send_bit(b ^ inv, c, gap);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    data_vld = 1'b0; clr = 1'b1;
    @(posedge clk);
    m_err = 0; m_bits = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_vld = 1'b0; clr = 1'b0; sat_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic align_window();
    for (int g = 0; g < WIN && m_wcnt != 0; g++) send_tx(1'b0, 1'b0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    total++; if (bit_err !== 1'b0) begin bad++; $display("FAIL reset_bit_err: got %0b want 0", bit_err); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_lock();
    for (int n = 1; n <= 1000; n++) begin
      send_tx(1'b0, 1'b0, (n <= 30) ? 49 : int'($urandom_range(0, 2)));
      total++;
      if (locked !== (n >= 23)) begin
        bad++; $display("FAIL clean_lock_bit%0d: locked=%0b want %0b", n, locked, (n >= 23));
      end
    end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
    total++; if (bit_cnt !== 32'd977) begin bad++; $display("FAIL clean_bit_cnt: got %0d want 977", bit_cnt); end
    idle(1);
  endtask

  task automatic test_single_error();
    int pulses = 0, drops = 0;
    pulse_clr();
    for (int n = 1; n <= 199; n++) send_tx(1'b0, 1'b0, 0);
    send_tx(1'b1, 1'b0, 0);
    total++; if (bit_err !== 1'b1) begin bad++; $display("FAIL single_pulse: bit_err=%0b want 1", bit_err); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
    idle(1);
    @(posedge clk); #1;
    total++; if (bit_err !== 1'b0) begin bad++; $display("FAIL single_pulse_width: bit_err=%0b want 0", bit_err); end
    for (int n = 1; n <= 500; n++) begin
      send_tx(1'b0, 1'b0, $urandom_range(0, 1));
      if (bit_err === 1'b1) pulses++;
      if (locked !== 1'b1) drops++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL single_after_pulses: got %0d want 0", pulses); end
    total++; if (drops != 0) begin bad++; $display("FAIL single_after_unlocked: got %0d want 0", drops); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL single_final_err: got %0d want 1", err_cnt); end
    total++; if (bit_cnt !== 32'd700) begin bad++; $display("FAIL single_final_bits: got %0d want 700", bit_cnt); end
    idle(1);
  endtask

  task automatic test_seven_errors();
    int drops = 0;
    align_window();
    pulse_clr();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < WIN; i++) begin
        send_tx((i % 9 == 0) && (i < 63), 1'b0, 0);
        if (locked !== 1'b1) drops++;
      end
    total++; if (drops != 0) begin bad++; $display("FAIL seven_unlocked: got %0d want 0", drops); end
    total++; if (err_cnt !== 16'd14) begin bad++; $display("FAIL seven_err_cnt: got %0d want 14", err_cnt); end
    total++; if (bit_cnt !== 32'd128) begin bad++; $display("FAIL seven_bit_cnt: got %0d want 128", bit_cnt); end
    idle(1);
  endtask

  task automatic test_loss_relock();
    align_window();
    pulse_clr();
    for (int i = 0; i < 22; i++) begin
      send_tx(i % 3 == 0, 1'b0, 0);
      total++;
      if (locked !== (i < 21)) begin bad++; $display("FAIL loss_bit%0d: locked=%0b want %0b", i, locked, (i < 21)); end
    end
    total++; if (bit_err !== 1'b1) begin bad++; $display("FAIL loss_pulse: bit_err=%0b want 1", bit_err); end
    total++; if (err_cnt !== 16'd8) begin bad++; $display("FAIL loss_err_cnt: got %0d want 8", err_cnt); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL loss_state: got %0d want 0", dbg_state); end
    for (int n = 1; n <= 23; n++) begin
      send_tx(1'b0, 1'b0, $urandom_range(0, 3));
      total++;
      if (locked !== (n == 23)) begin bad++; $display("FAIL relock_bit%0d: locked=%0b want %0b", n, locked, (n == 23)); end
    end
    total++; if (err_cnt !== 16'd8) begin bad++; $display("FAIL relock_err_cnt: got %0d want 8", err_cnt); end
    idle(1);
  endtask

  task automatic test_clr_collision();
    send_tx(1'b1, 1'b1, 0);
    total++; if (bit_err !== 1'b1) begin bad++; $display("FAIL clr_coll_pulse: bit_err=%0b want 1", bit_err); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clr_coll_err: got %0d want 0", err_cnt); end
    total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL clr_coll_bits: got %0d want 0", bit_cnt); end
    send_tx(1'b1, 1'b0, 0);
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL clr_after_err: got %0d want 1", err_cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_keeps_lock: got %0b want 1", locked); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    send_tx(1'b1, 1'b0, 0);
    total++; if (bit_err !== 1'b1) begin bad++; $display("FAIL b2b_first: bit_err=%0b want 1", bit_err); end
    send_tx(1'b1, 1'b0, 0);
    total++; if (bit_err !== 1'b1) begin bad++; $display("FAIL b2b_second: bit_err=%0b want 1", bit_err); end
    send_tx(1'b0, 1'b0, 0);
    total++; if (bit_err !== 1'b0) begin bad++; $display("FAIL b2b_clean: bit_err=%0b want 0", bit_err); end
    total++; if (err_cnt !== 16'd3) begin bad++; $display("FAIL b2b_err_cnt: got %0d want 3", err_cnt); end
    idle(1);
  endtask

  task automatic test_reset_mid_lock();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rstmid_pre_locked: got %0b want 1", locked); end
    @(posedge clk);
    #3;
    data_vld = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({locked, bit_err, err_cnt, bit_cnt, dbg_state} !== '0) begin
      bad++; $display("FAIL rstmid_async: locked=%0b bit_err=%0b err=%0d bits=%0d st=%0d want all 0",
                      locked, bit_err, err_cnt, bit_cnt, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 1; n <= 23; n++) begin
      send_tx(1'b0, 1'b0, $urandom_range(0, 2));
      total++;
      if (locked !== (n == 23)) begin bad++; $display("FAIL rstmid_relock_bit%0d: locked=%0b want %0b", n, locked, (n == 23)); end
    end
    idle(1);
  endtask

  task automatic test_degenerate_zero();
    int ups = 0;
    do_reset();
    for (int n = 1; n <= 500; n++) begin
      send_bit(1'b0, 1'b0, 0);
      if (locked !== 1'b0) ups++;
    end
    total++; if (ups != 0) begin bad++; $display("FAIL zero_locked: got %0d cycles want 0", ups); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL zero_state: got %0d want 0", dbg_state); end
    idle(1);
  endtask

  task automatic test_verify_error();
    do_reset();
    for (int n = 1; n <= 21; n++) send_tx(1'b0, 1'b0, 0);
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL verify_state: got %0d want 1", dbg_state); end
    send_tx(1'b1, 1'b0, 0);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL verify_restart: got %0d want 0", dbg_state); end
    total++; if (bit_err !== 1'b0) begin bad++; $display("FAIL verify_no_pulse: got %0b want 0", bit_err); end
    for (int n = 1; n <= 23; n++) begin
      send_tx(1'b0, 1'b0, 0);
      total++;
      if (locked !== (n == 23)) begin bad++; $display("FAIL verify_relock_bit%0d: locked=%0b want %0b", n, locked, (n == 23)); end
    end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL verify_err_cnt: got %0d want 0", err_cnt); end
    idle(1);
  endtask

  task automatic test_random();
    bit inv, c;
    for (int i = 0; i < 1500; i++) begin
      inv = ((i / 250) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      c   = ($urandom_range(0, 96) == 0);
      send_tx(inv, c, $urandom_range(0, 2));
      total++; if (locked !== m_locked) begin bad++; $display("FAIL rnd_locked_%0d: got %0b want %0b", i, locked, m_locked); end
      total++; if (bit_err !== m_bit_err) begin bad++; $display("FAIL rnd_bit_err_%0d: got %0b want %0b", i, bit_err, m_bit_err); end
      total++; if (err_cnt !== 16'(m_err)) begin bad++; $display("FAIL rnd_err_cnt_%0d: got %0d want %0d", i, err_cnt, m_err); end
      total++; if (bit_cnt !== 32'(m_bits)) begin bad++; $display("FAIL rnd_bit_cnt_%0d: got %0d want %0d", i, bit_cnt, m_bits); end
    end
    idle(1);
  endtask

  task automatic test_saturation();
    bit b;
    int drops = 0;
    do_reset();
    for (int n = 1; n <= 23; n++) begin
      next_tx(b);
      @(negedge clk); sat_in = b; sat_vld = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (sat_locked !== 1'b1) begin bad++; $display("FAIL sat_lock: got %0b want 1", sat_locked); end
    for (int n = 1; n <= 65540; n++) begin
      next_tx(b);
      @(negedge clk); sat_in = ~b; sat_vld = 1'b1;
      @(posedge clk); #1;
      if (sat_locked !== 1'b1) drops++;
      if (n == 65534) begin
        total++; if (sat_err_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_near: got %0h want fffe", sat_err_cnt); end
      end
      if (n == 65535) begin
        total++; if (sat_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %0h want ffff", sat_err_cnt); end
      end
    end
    total++; if (sat_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h want ffff", sat_err_cnt); end
    total++; if (sat_bit_cnt !== 32'd65540) begin bad++; $display("FAIL sat_bits: got %0d want 65540", sat_bit_cnt); end
    total++; if (sat_bit_err !== 1'b1) begin bad++; $display("FAIL sat_pulse: got %0b want 1", sat_bit_err); end
    total++; if (drops != 0) begin bad++; $display("FAIL sat_unlocked: got %0d want 0", drops); end
    idle(1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    data_in = 1'b0; data_vld = 1'b0; clr = 1'b0;
    sat_in = 1'b0; sat_vld = 1'b0; sat_clr = 1'b0;
    tx_q.delete();
    for (int i = 0; i < WIDTH; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
    tx_q[0] = 1'b1;
    model_reset();

    test_reset();
    test_clean_lock();
    test_single_error();
    test_seven_errors();
    test_loss_relock();
    test_clr_collision();
    test_back_to_back();
    test_reset_mid_lock();
    test_degenerate_zero();
    test_verify_error();
    test_random();
    test_saturation();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
